tf_stage_scheduler: RTL and testbench

Twiddle-factor address scheduler for the radix-2, 8192-point FFT pipeline. On `start` it latches a stage number and emits 4096 twiddle ROM addresses, one per non-stalled clock. It uses stride/wrap addressing so that one shared 4096-entry twiddle ROM serves every stage. It sits between the stage sequencer and the twiddle BRAM, driving the BRAM's `ena`/`addra` and producing a valid/last strobe aligned to the BRAM's `douta`.

---
 rtl/tf_sched_pkg.sv | 18 +
 rtl/tf_stage_scheduler_if.sv | 26 ++
 rtl/tf_valid_pipe.sv | 45 ++++
 rtl/tf_stage_scheduler.sv | 116 +++++++++++
 tb/tb_tf_stage_scheduler.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tf_sched_pkg.sv
// Shared types and constants for the twiddle-factor stage scheduler.
package tf_sched_pkg;

  localparam int FFT_LOG2N      = 13;
  localparam int TF_ADDR_LEN    = 12;
  localparam int BFLY_PER_STAGE = 4096;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic valid;
    logic last;
  } tf_tag_t;

endpackage

// File: rtl/tf_stage_scheduler_if.sv
// Sequencer-side request/stall and twiddle ROM strobes of the stage scheduler.
interface tf_stage_scheduler_if #(
  parameter int TF_ADDR_W = 12,
  parameter int STAGE_W   = 4
);
  logic                 start;
  logic [STAGE_W-1:0]   stage;
  logic                 stall;
  logic                 tf_en;
  logic [TF_ADDR_W-1:0] tf_addr;
  logic                 tf_valid;
  logic                 tf_last;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, stage, stall,
    input  tf_en, tf_addr, tf_valid, tf_last, busy, done, err
  );

  modport slave (
    input  start, stage, stall,
    output tf_en, tf_addr, tf_valid, tf_last, busy, done, err
  );
endinterface

// File: rtl/tf_valid_pipe.sv
// Free-running {valid,last} delay line matching the twiddle ROM read latency.
module tf_valid_pipe
  import tf_sched_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last,
  output logic o_empty
);

  tf_tag_t r_pipe [DEPTH];
  logic    w_pending;

  // shift one tag per clock, never stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '{valid: 1'b0, last: 1'b0};
      end
    end else begin
      r_pipe[0] <= '{valid: i_valid, last: i_last};
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // "empty" ignores the output stage: it retires on the next edge regardless
  always_comb begin
    w_pending = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_pending = w_pending | r_pipe[k].valid;
    end
  end

  assign o_empty = ~w_pending;
  assign o_valid = r_pipe[DEPTH-1].valid;
  assign o_last  = r_pipe[DEPTH-1].last;

endmodule

// File: rtl/tf_stage_scheduler.sv
// Twiddle ROM address scheduler: one stride/wrap address per non-stalled clock per FFT stage.
// Optional TF_STAGE_CHECK_EN rejects out-of-range stages (err pulse) instead of saturating them.
module tf_stage_scheduler
  import tf_sched_pkg::*;
#(
  parameter int bram_addr_len = FFT_LOG2N,
  parameter int tf_addr_len   = TF_ADDR_LEN,
  parameter int rom_latency   = 1,
  parameter int stage_len     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tf_stage_scheduler_if.slave  tf_bus
);

  localparam logic [stage_len-1:0]   LP_N      = stage_len'(bram_addr_len);
  localparam logic [tf_addr_len-1:0] LP_J_LAST = {tf_addr_len{1'b1}};

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [tf_addr_len-1:0] r_j;
  logic [stage_len-1:0]   r_s_q;
  logic                   r_err;
  logic [stage_len-1:0]   w_stage_lat;
  logic [stage_len-1:0]   w_shift;
  logic                   w_bad_stage;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_en;
  logic                   w_issue_last;
  logic                   w_pipe_empty;
  logic                   w_valid;
  logic                   w_last;

  assign w_bad_stage = (tf_bus.stage == {stage_len{1'b0}}) || (tf_bus.stage > LP_N);

`ifdef TF_STAGE_CHECK_EN
  assign w_accept    = tf_bus.start && !w_bad_stage;
  assign w_reject    = tf_bus.start && w_bad_stage;
  assign w_stage_lat = tf_bus.stage;
`else
  assign w_accept = tf_bus.start;
  assign w_reject = 1'b0;

  // clamp the requested stage into 1..bram_addr_len
  always_comb begin
    w_stage_lat = tf_bus.stage;
    if (tf_bus.stage == {stage_len{1'b0}}) begin
      w_stage_lat = {{(stage_len-1){1'b0}}, 1'b1};
    end else if (tf_bus.stage > LP_N) begin
      w_stage_lat = LP_N;
    end else begin
      w_stage_lat = tf_bus.stage;
    end
  end
`endif

  assign w_en         = (r_state == ST_RUN) && !tf_bus.stall;
  assign w_issue_last = w_en && (r_j == LP_J_LAST);
  assign w_shift      = LP_N - r_s_q;

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
      ST_RUN:   w_state_nxt = w_issue_last ? ST_DRAIN : ST_RUN;
      ST_DRAIN: w_state_nxt = w_pipe_empty ? ST_DONE : ST_DRAIN;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // state, butterfly counter, latched stage and reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_j     <= {tf_addr_len{1'b0}};
      r_s_q   <= {{(stage_len-1){1'b0}}, 1'b1};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (r_state == ST_IDLE) && w_reject;
      if ((r_state == ST_IDLE) && w_accept) begin
        r_j   <= {tf_addr_len{1'b0}};
        r_s_q <= w_stage_lat;
      end else if (w_en) begin
        r_j   <= r_j + {{(tf_addr_len-1){1'b0}}, 1'b1};
      end else begin
        r_j   <= r_j;
      end
    end
  end

  tf_valid_pipe #(
    .DEPTH (rom_latency)
  ) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_en),
    .i_last  (w_issue_last),
    .o_valid (w_valid),
    .o_last  (w_last),
    .o_empty (w_pipe_empty)
  );

  // high bits shifted out give the wrap every 2^(s-1) butterflies
  assign tf_bus.tf_addr  = r_j << w_shift;
  assign tf_bus.tf_en    = w_en;
  assign tf_bus.tf_valid = w_valid;
  assign tf_bus.tf_last  = w_last;
  assign tf_bus.busy     = (r_state != ST_IDLE);
  assign tf_bus.done     = (r_state == ST_DONE);
  assign tf_bus.err      = r_err;

endmodule

// File: tb/tb_tf_stage_scheduler.sv
// Directed self-checking bench for tf_stage_scheduler (rom_latency = 1).
module tb_tf_stage_scheduler;

  localparam int L = 1;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   ab;

  tf_stage_scheduler_if #(.TF_ADDR_W(12), .STAGE_W(4)) bus ();

  tf_stage_scheduler #(
    .bram_addr_len (13),
    .tf_addr_len   (12),
    .rom_latency   (L),
    .stage_len     (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tf_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic logic [31:0] out_vec();
    return {14'd0, bus.tf_en, bus.tf_valid, bus.tf_last, bus.busy, bus.done, bus.err, bus.tf_addr};
  endfunction

  // Runs one stage from IDLE. Entry/exit: 2 time units after a rising edge.
  task automatic run_stage(input int s, input int exp_s, input int stall_j, input int stall_n,
                           input int mid_cyc, input int abort_j, output bit aborted);
    int jexp = 0, cyc = 0, n_en = 0, n_val = 0, n_last = 0;
    int last_cyc = -1, done_cyc = -1, first_en = -1, first_val = -1;
    int addr_bad = 0, n_err = 0, busy_bad = 0, stall_bad = 0, stall_left = stall_n;
    logic [11:0] exp_a;
    aborted = 1'b0;
    bus.start = 1'b1;
    bus.stage = 4'(s);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (done_cyc < 0 && cyc < 4200 + stall_n) begin
      if (jexp == abort_j) begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        check_eq($sformatf("s%0d_pre_abort_addr", s), addr_bad, 0);
        aborted = 1'b1;
        return;
      end
      bus.stall = (jexp == stall_j) && (stall_left > 0);
      if (bus.stall) stall_left--;
      bus.start = (cyc == mid_cyc);
      bus.stage = 4'd3;
      #1;
      if (bus.stall && bus.tf_en) stall_bad++;
      if (bus.tf_en) begin
        exp_a = 12'((jexp % (1 << (exp_s - 1))) * (1 << (13 - exp_s)));
        if (bus.tf_addr !== exp_a) addr_bad++;
        if (first_en < 0) first_en = cyc;
        jexp++;
        n_en++;
      end
      if (bus.tf_valid) begin
        if (first_val < 0) first_val = cyc;
        n_val++;
      end
      if (bus.tf_last) begin
        n_last++;
        last_cyc = cyc;
      end
      if (bus.err) n_err++;
      if (!bus.busy) busy_bad++;
      if (bus.done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #1;
    check_eq($sformatf("s%0d_first_en_cycle", s), first_en, 1);
    check_eq($sformatf("s%0d_en_count", s), n_en, 4096);
    check_eq($sformatf("s%0d_addr_errors", s), addr_bad, 0);
    check_eq($sformatf("s%0d_en_during_stall", s), stall_bad, 0);
    check_eq($sformatf("s%0d_first_valid_cycle", s), first_val, 1 + L);
    check_eq($sformatf("s%0d_valid_count", s), n_val, 4096);
    check_eq($sformatf("s%0d_last_count", s), n_last, 1);
    check_eq($sformatf("s%0d_last_cycle", s), last_cyc, 4096 + L + stall_n);
    check_eq($sformatf("s%0d_done_cycle", s), done_cyc, 4097 + L + stall_n);
    check_eq($sformatf("s%0d_busy_gaps", s), busy_bad, 0);
    check_eq($sformatf("s%0d_err_pulses", s), n_err, 0);
    check_eq($sformatf("s%0d_idle_after_done", s), out_vec(), 32'd0);
  endtask

`ifdef TF_STAGE_CHECK_EN
  task automatic reject_stage(input int s);
    bus.start = 1'b1;
    bus.stage = 4'(s);
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
    check_eq($sformatf("rej%0d_err", s), {31'd0, bus.err}, 32'd1);
    check_eq($sformatf("rej%0d_busy", s), {31'd0, bus.busy}, 32'd0);
    check_eq($sformatf("rej%0d_en", s), {31'd0, bus.tf_en}, 32'd0);
    @(posedge clk); #2;
    check_eq($sformatf("rej%0d_err_cleared", s), {31'd0, bus.err}, 32'd0);
    check_eq($sformatf("rej%0d_busy_later", s), {31'd0, bus.busy}, 32'd0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stage = 4'd0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("outputs_in_reset", out_vec(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("outputs_after_reset", out_vec(), 32'd0);
    #1;

    run_stage(9, 9, -1, 0, -1, -1, ab);
    run_stage(1, 1, -1, 0, -1, -1, ab);
    run_stage(13, 13, -1, 0, -1, -1, ab);
    run_stage(5, 5, 100, 3, -1, -1, ab);
    run_stage(11, 11, -1, 0, 50, -1, ab);

    run_stage(7, 7, -1, 0, -1, 2000, ab);
    check_eq("abort_reached", {31'd0, ab}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("outputs_mid_run_reset", out_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("outputs_reset_held", out_vec(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("outputs_after_mid_reset", out_vec(), 32'd0);
    #1;
    run_stage(2, 2, -1, 0, -1, -1, ab);

`ifdef TF_STAGE_CHECK_EN
    reject_stage(0);
    reject_stage(14);
`else
    run_stage(0, 1, -1, 0, -1, -1, ab);
    run_stage(14, 13, -1, 0, -1, -1, ab);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
